// File: rtl/ifetch_seq.sv
// ifetch_seq: instruction-fetch sequencer that owns the word-address PC and the I-mem read port.
// Define IFETCH_FAULT_EN to make an accepted MemErr response latch a sticky Fault and halt fetch.
module ifetch_seq #(
   parameter int unsigned      PC_W     = 30,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            ReqValid,
   input  logic            ReqReady,
   output logic [PC_W-1:0] ReqAddr,
   input  logic            RespValid,
   input  logic [31:0]     RespData,
   input  logic            MemErr,
   output logic            InstrValid,
   input  logic            InstrReady,
   output logic [31:0]     Instr,
   output logic [PC_W-1:0] InstrPC,
   input  logic            Redirect,
   input  logic [PC_W-1:0] RedirectPC,
   output logic            Fault
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef IFETCH_FAULT_EN
   localparam logic [2:0] S_FAULT = 3'd4;
`endif

   logic [2:0]      state;
   logic [PC_W-1:0] pc;
   // Set when the outstanding response belongs to a path abandoned by a redirect.
   logic            discard;

   assign ReqValid   = (state == S_REQ);
   assign ReqAddr    = pc;
   assign InstrValid = (state == S_HOLD);

`ifdef IFETCH_FAULT_EN
   logic fault_q;
   assign Fault = fault_q;
`else
   logic unused_mem_err;
   assign unused_mem_err = MemErr;
   assign Fault          = 1'b0;
`endif

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         discard <= 1'b0;
         Instr   <= '0;
         InstrPC <= RESET_PC;
`ifdef IFETCH_FAULT_EN
         fault_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_REQ;
               if (Redirect) pc <= RedirectPC;
            end

            S_REQ: begin
               if (ReqReady) begin
                  InstrPC <= pc;
                  state   <= S_WAIT;
               end
               // An accepted request already carries the old PC, so its data must be dropped.
               if (Redirect) begin
                  pc <= RedirectPC;
                  if (ReqReady) discard <= 1'b1;
               end
            end

            S_WAIT: begin
               if (RespValid) begin
                  discard <= 1'b0;
                  if (discard || Redirect) begin
                     state <= S_REQ;
                  end
`ifdef IFETCH_FAULT_EN
                  else if (MemErr) begin
                     fault_q <= 1'b1;
                     state   <= S_FAULT;
                  end
`endif
                  else begin
                     Instr <= RespData;
                     state <= S_HOLD;
                  end
               end else if (Redirect) begin
                  discard <= 1'b1;
               end
               if (Redirect) pc <= RedirectPC;
            end

            S_HOLD: begin
               // Redirect wins over the decode handshake: the held word is simply abandoned.
               if (Redirect) begin
                  pc    <= RedirectPC;
                  state <= S_REQ;
               end else if (InstrReady) begin
                  pc    <= pc + PC_W'(1);
                  state <= S_REQ;
               end
            end

`ifdef IFETCH_FAULT_EN
            S_FAULT: begin
               state <= S_FAULT;
            end
`endif

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: transaction-level model compared every cycle, plus directed literals.
// Build with IFETCH_FAULT_EN defined to exercise the sticky-fault path.
module tb_ifetch_seq;

   localparam logic [29:0] RST_PC = 30'h100;
`ifdef IFETCH_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        ReqValid, ReqReady;
   logic [29:0] ReqAddr;
   logic        RespValid;
   logic [31:0] RespData;
   logic        MemErr;
   logic        InstrValid, InstrReady;
   logic [31:0] Instr;
   logic [29:0] InstrPC;
   logic        Redirect;
   logic [29:0] RedirectPC;
   logic        Fault;

   ifetch_seq #(.PC_W(30), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
      .RespValid(RespValid), .RespData(RespData), .MemErr(MemErr),
      .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC),
      .Redirect(Redirect), .RedirectPC(RedirectPC), .Fault(Fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int iv_count = 0;

   // Observed traffic: accepted request addresses and completed decode handshakes.
   logic [29:0] acc_log[$];
   logic [29:0] hs_pc[$];
   logic [31:0] hs_data[$];
   int          hs_cyc[$];

   // Memory: answers an accepted request mem_lat cycles later with data = {2'b0, address}.
   bit          mem_busy;
   int          mem_cnt;
   int          mem_lat;
   logic [29:0] mem_addr;
   bit          mem_err;
   bit          stale_resp;

   // Model: which transaction is in flight, not how the sequencer encodes it.
   bit          m_started, m_out, m_drop, m_held, m_fault;
   logic [29:0] m_pc, m_ipc;
   logic [31:0] m_instr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_out     = 1'b0;
      m_drop    = 1'b0;
      m_held    = 1'b0;
      m_fault   = 1'b0;
      m_pc      = RST_PC;
      m_ipc     = RST_PC;
      m_instr   = '0;
   endtask

   task automatic model_step();
      if (m_fault) begin
         // stuck until reset
      end else if (!m_started) begin
         m_started = 1'b1;
         if (Redirect) m_pc = RedirectPC;
      end else if (m_held) begin
         if (Redirect) begin
            m_pc   = RedirectPC;
            m_held = 1'b0;
         end else if (InstrReady) begin
            m_pc   = m_pc + 30'd1;
            m_held = 1'b0;
         end
      end else if (m_out) begin
         if (RespValid) begin
            m_out = 1'b0;
            if (m_drop || Redirect) m_drop = 1'b0;
            else if (FAULT_EN && MemErr) m_fault = 1'b1;
            else begin
               m_held  = 1'b1;
               m_instr = RespData;
            end
            if (Redirect) m_pc = RedirectPC;
         end else if (Redirect) begin
            m_pc   = RedirectPC;
            m_drop = 1'b1;
         end
      end else begin
         if (ReqReady) begin
            m_out = 1'b1;
            m_ipc = m_pc;
         end
         if (Redirect) begin
            m_pc = RedirectPC;
            if (ReqReady) m_drop = 1'b1;
         end
      end
   endtask

   // One clock cycle: enter at a falling edge, compare 1 time unit before the rising edge.
   task automatic tick();
      #4;
      if (reset) model_reset();
      check("ReqValid",   32'(ReqValid),   32'(m_started && !m_out && !m_held && !m_fault));
      check("ReqAddr",    32'(ReqAddr),    32'(m_pc));
      check("InstrValid", 32'(InstrValid), 32'(m_held));
      check("Instr",      Instr,           m_instr);
      check("InstrPC",    32'(InstrPC),    32'(m_ipc));
      check("Fault",      32'(Fault),      32'(m_fault));

      RespValid = 1'b0;
      MemErr    = 1'b0;
      RespData  = '0;
      if (reset) mem_busy = 1'b0;
      if (stale_resp) begin
         RespValid = 1'b1;
         RespData  = 32'hDEAD_BEEF;
      end else if (mem_busy) begin
         if (mem_cnt <= 1) begin
            RespValid = 1'b1;
            RespData  = 32'(mem_addr);
            MemErr    = mem_err;
            mem_busy  = 1'b0;
         end else begin
            mem_cnt--;
         end
      end

      if (!reset) begin
         if (ReqValid && ReqReady) acc_log.push_back(ReqAddr);
         if (InstrValid) iv_count++;
         if (InstrValid && InstrReady && !Redirect) begin
            hs_pc.push_back(InstrPC);
            hs_data.push_back(Instr);
            hs_cyc.push_back(cyc);
         end
         model_step();
         if (ReqValid && ReqReady) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = ReqAddr;
         end
      end
      cyc++;
      #6;
   endtask

   task automatic wait_hs(input int target, input int budget);
      int n = 0;
      while (hs_pc.size() < target && n < budget) begin
         tick();
         n++;
      end
      check("wait_handshake", 32'(hs_pc.size() >= target), 32'd1);
   endtask

   task automatic wait_req(input logic [29:0] addr, input int budget);
      int n = 0;
      while (!(ReqValid && ReqAddr == addr) && n < budget) begin
         tick();
         n++;
      end
      check("wait_request", 32'(ReqValid && ReqAddr == addr), 32'd1);
   endtask

   task automatic wait_iv(input int budget);
      int n = 0;
      while (!InstrValid && n < budget) begin
         tick();
         n++;
      end
      check("wait_instr_valid", 32'(InstrValid), 32'd1);
   endtask

   initial begin
      int base_iv, base_hs, sz;
      reset      = 1'b1;
      ReqReady   = 1'b1;
      InstrReady = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = '0;
      RespValid  = 1'b0;
      RespData   = '0;
      MemErr     = 1'b0;
      mem_busy   = 1'b0;
      mem_cnt    = 0;
      mem_lat    = 1;
      mem_addr   = '0;
      mem_err    = 1'b0;
      stale_resp = 1'b0;
      model_reset();
      tick();
      tick();

      // Reset values.
      check("rst_ReqValid",   32'(ReqValid),   32'd0);
      check("rst_ReqAddr",    32'(ReqAddr),    32'h100);
      check("rst_InstrPC",    32'(InstrPC),    32'h100);
      check("rst_Instr",      Instr,           32'd0);
      check("rst_InstrValid", 32'(InstrValid), 32'd0);

      // Sequential fetch at full rate.
      reset = 1'b0;
      tick();
      check("first_edge_ReqValid", 32'(ReqValid), 32'd1);
      wait_hs(3, 20);
      for (int i = 0; i < 3; i++) begin
         check("seq_req_addr", 32'(acc_log[i]), 32'h100 + 32'(i));
         check("seq_instr_pc", 32'(hs_pc[i]),   32'h100 + 32'(i));
         check("seq_instr",    hs_data[i],      32'h100 + 32'(i));
      end
      check("seq_rate_0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      check("seq_rate_1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

      // Request backpressure, then decode backpressure.
      ReqReady = 1'b0;
      repeat (4) tick();
      check("bp_req_held_valid", 32'(ReqValid), 32'd1);
      check("bp_req_held_addr",  32'(ReqAddr),  32'h103);
      ReqReady   = 1'b1;
      InstrReady = 1'b0;
      wait_iv(10);
      repeat (5) tick();
      check("bp_hold_valid",   32'(InstrValid), 32'd1);
      check("bp_hold_instr",   Instr,           32'h103);
      check("bp_hold_instrpc", 32'(InstrPC),    32'h103);
      InstrReady = 1'b1;
      wait_hs(4, 10);
      check("bp_accept_count", 32'(acc_log.size()), 32'd4);
      check("bp_no_skip",      32'(hs_pc[3]),       32'h103);

      // Redirect while waiting for a slow response.
      mem_lat = 3;
      tick();
      Redirect   = 1'b1;
      RedirectPC = 30'h200;
      base_iv    = iv_count;
      tick();
      Redirect = 1'b0;
      wait_req(30'h200, 10);
      check("wait_redir_dropped", 32'(iv_count - base_iv), 32'd0);
      sz = acc_log.size();
      check("wait_redir_prev_req", 32'(acc_log[sz-1]), 32'h104);
      mem_lat = 1;

      // Redirect on an accepted request, then redirect in HOLD with InstrReady high.
      Redirect   = 1'b1;
      RedirectPC = 30'h10;
      InstrReady = 1'b0;
      tick();
      Redirect = 1'b0;
      wait_iv(10);
      check("hold_instr_pc", 32'(InstrPC), 32'h10);
      check("hold_instr",    Instr,        32'h10);
      base_hs    = hs_pc.size();
      Redirect   = 1'b1;
      RedirectPC = 30'h3FFF_FFFF;
      InstrReady = 1'b1;
      tick();
      Redirect = 1'b0;
      check("hold_redir_iv_fall", 32'(InstrValid), 32'd0);
      check("hold_redir_addr",    32'(ReqAddr),    32'h3FFF_FFFF);
      wait_req(30'h0, 20);
      check("wrap_hs_count", 32'(hs_pc.size() - base_hs), 32'd1);
      check("wrap_hs_pc",    32'(hs_pc[hs_pc.size()-1]), 32'h3FFF_FFFF);
      check("wrap_hs_data",  hs_data[hs_data.size()-1], 32'h3FFF_FFFF);
      sz = acc_log.size();
      check("redir_acc_200",  32'(acc_log[sz-3]), 32'h200);
      check("redir_acc_10",   32'(acc_log[sz-2]), 32'h10);
      check("redir_acc_wrap", 32'(acc_log[sz-1]), 32'h3FFF_FFFF);

      // Memory error response.
      mem_err = 1'b1;
`ifdef IFETCH_FAULT_EN
      begin
         int n = 0;
         while (!Fault && n < 10) begin
            tick();
            n++;
         end
      end
      sz         = acc_log.size();
      Redirect   = 1'b1;
      RedirectPC = 30'h55;
      tick();
      Redirect = 1'b0;
      repeat (5) tick();
      check("fault_sticky",     32'(Fault),          32'd1);
      check("fault_no_req",     32'(ReqValid),       32'd0);
      check("fault_no_instr",   32'(InstrValid),     32'd0);
      check("fault_redir_ign",  32'(ReqAddr),        32'h0);
      check("fault_no_accepts", 32'(acc_log.size()), 32'(sz));
`else
      base_hs = hs_pc.size();
      wait_hs(base_hs + 1, 10);
      check("memerr_ignored_pc",   32'(hs_pc[hs_pc.size()-1]), 32'h0);
      check("memerr_ignored_data", hs_data[hs_data.size()-1],  32'h0);
      check("memerr_no_fault",     32'(Fault),                 32'd0);
`endif
      mem_err = 1'b0;
      reset   = 1'b1;
      tick();
      check("reset_clears_fault", 32'(Fault),    32'd0);
      check("reset_clears_req",   32'(ReqValid), 32'd0);

      // Reset in the middle of WAIT, with a stale response arriving afterwards.
      mem_lat = 3;
      reset   = 1'b0;
      tick();
      tick();
      reset      = 1'b1;
      stale_resp = 1'b1;
      tick();
      check("midwait_rst_req",     32'(ReqValid),   32'd0);
      check("midwait_rst_addr",    32'(ReqAddr),    32'h100);
      check("midwait_rst_instrpc", 32'(InstrPC),    32'h100);
      check("midwait_rst_iv",      32'(InstrValid), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      stale_resp = 1'b0;
      mem_lat    = 1;
      check("post_rst_req",  32'(ReqValid), 32'd1);
      check("post_rst_addr", 32'(ReqAddr),  32'h100);
      base_hs = hs_pc.size();
      wait_hs(base_hs + 1, 10);
      check("post_rst_pc",   32'(hs_pc[hs_pc.size()-1]), 32'h100);
      check("post_rst_data", hs_data[hs_data.size()-1],  32'h100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
